// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start bit, N data bits LSB first, parity bit, stop bit.
// Each bit lasts CLKS_PER_BIT cycles, and tx is driven straight from a register.
module parity_frame_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD          = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         tx,
    output logic         busy,
    output logic         parity_o,
    output logic         done_tick
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
    localparam logic              ODD_BIT   = (ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_reg, state_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [N-1:0]      shift_reg, shift_next;
    logic              parity_reg, parity_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              accept;
    logic              bit_end;

    assign din_ready = (state_reg == IDLE) && !reset;
    assign accept    = din_valid && din_ready;
    assign bit_end   = (tick_reg == TICK_LAST);

    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        done_next   = 1'b0;

        // The tick counter runs in every frame state and wraps at the bit boundary.
        if (state_reg != IDLE) begin
            tick_next = bit_end ? '0 : tick_reg + TICK_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next  = din;
                    parity_next = (^din) ^ ODD_BIT;
                    tick_next   = '0;
                    bit_next    = '0;
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = PARITY;
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is chosen from the state being entered so tx stays registered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign parity_o  = parity_reg;
    assign done_tick = done_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed and randomized checks of parity_frame_tx: even/odd parity, back-to-back
// frames, mid-frame reset, the single-cycle-bit case and an in-order receiver scoreboard.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       valid0, valid1;
    logic       tx0, busy0, par0, done0, ready0;
    logic       tx1, busy1, par1, done1, ready1;
    logic [0:0] din2;
    logic       valid2;
    logic       tx2, busy2, par2, done2, ready2;

    bit   sel;
    logic tx_s, busy_s, par_s, done_s, ready_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.N(8), .CLKS_PER_BIT(4), .ODD(0)) dut0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(valid0), .din_ready(ready0),
        .tx(tx0), .busy(busy0), .parity_o(par0), .done_tick(done0));

    parity_frame_tx #(.N(8), .CLKS_PER_BIT(4), .ODD(1)) dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(valid1), .din_ready(ready1),
        .tx(tx1), .busy(busy1), .parity_o(par1), .done_tick(done1));

    parity_frame_tx #(.N(1), .CLKS_PER_BIT(1), .ODD(0)) dut2 (
        .clk(clk), .reset(reset), .din(din2), .din_valid(valid2), .din_ready(ready2),
        .tx(tx2), .busy(busy2), .parity_o(par2), .done_tick(done2));

    assign tx_s    = sel ? tx1    : tx0;
    assign busy_s  = sel ? busy1  : busy0;
    assign par_s   = sel ? par1   : par0;
    assign done_s  = sel ? done1  : done0;
    assign ready_s = sel ? ready1 : ready0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit slot k of an 8-bit frame.
    function automatic logic exp_bit(input logic [7:0] w, input logic odd, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return w[k-1];
        else if (k == 9) return (^w) ^ odd;
        else             return 1'b1;
    endfunction

    task automatic drive_valid(input logic v);
        if (sel) valid1 = v;
        else     valid0 = v;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!ready_s && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", {31'b0, ready_s}, 32'd1);
    endtask

    task automatic send(input logic [7:0] w);
        wait_ready();
        din = w;
        drive_valid(1'b1);
        @(posedge clk);
        #1 drive_valid(1'b0);
    endtask

    // Called just after the accept edge; ends at the negedge of the done_tick cycle.
    task automatic check_frame(input logic [7:0] w);
        logic odd;
        odd = sel;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            check("tx_bit", {31'b0, tx_s}, {31'b0, exp_bit(w, odd, c / 4)});
            check("busy_in_frame", {31'b0, busy_s}, 32'd1);
            check("done_in_frame", {31'b0, done_s}, 32'd0);
            check("ready_in_frame", {31'b0, ready_s}, 32'd0);
            if (c == 0) check("parity_o", {31'b0, par_s}, {31'b0, (^w) ^ odd});
        end
        @(negedge clk);
        check("done_tick", {31'b0, done_s}, 32'd1);
        check("idle_tx", {31'b0, tx_s}, 32'd1);
        check("idle_busy", {31'b0, busy_s}, 32'd0);
        check("idle_ready", {31'b0, ready_s}, 32'd1);
        $display("frame dut%0d word %02h parity %0b", sel, w, par_s);
    endtask

    // Randomized-phase scoreboard: accepted words in, decoded frames out.
    logic [7:0] acc_q[$];
    bit         rx_en = 1'b0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    int         n_acc = 0;
    int         n_rx = 0;
    logic [7:0] rx_word;
    logic       rx_par;

    always @(negedge clk) begin
        if (rx_en && valid0 && ready0) begin
            acc_q.push_back(din);
            n_acc++;
        end
        if (rx_en && busy0) check("ready_while_busy", {31'b0, ready0}, 32'd0);
    end

    always @(negedge clk) begin
        if (rx_en) begin
            if (!rx_active) begin
                if (tx0 == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % 4 == 2) begin
                    int k;
                    k = rx_cnt / 4;
                    if (k >= 1 && k <= 8) rx_word[k-1] = tx0;
                    else if (k == 9) rx_par = tx0;
                    else if (k == 10) begin
                        check("rx_stop", {31'b0, tx0}, 32'd1);
                        if (acc_q.size() == 0) begin
                            check("rx_unexpected", 32'd1, 32'd0);
                        end else begin
                            logic [7:0] w;
                            w = acc_q.pop_front();
                            check("rx_word", {24'b0, rx_word}, {24'b0, w});
                            check("rx_parity", {31'b0, rx_par}, {31'b0, ^w});
                            $display("rx word %02h parity %0b expected %02h", rx_word, rx_par, w);
                        end
                        n_rx++;
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    logic exp2 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        reset  = 1'b1;
        sel    = 1'b0;
        din    = 8'h00;
        valid0 = 1'b0;
        valid1 = 1'b0;
        din2   = 1'b0;
        valid2 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'b0, tx0}, 32'd1);
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_done", {31'b0, done0}, 32'd0);
        check("rst_parity", {31'b0, par0}, 32'd0);
        check("rst_ready", {31'b0, ready0}, 32'd0);
        check("rst_tx_c1", {31'b0, tx2}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, ready0}, 32'd1);

        // Even parity, 0xA5: four ones so the parity bit is 0.
        send(8'hA5);
        check_frame(8'hA5);

        // 0x07 with 0x3C held pending through the frame; 0x3C goes in the done_tick cycle.
        wait_ready();
        din    = 8'h07;
        valid0 = 1'b1;
        @(posedge clk);
        #1 din = 8'h3C;
        check_frame(8'h07);
        @(posedge clk);
        #1 valid0 = 1'b0;
        check_frame(8'h3C);

        // Odd parity instance.
        sel = 1'b1;
        send(8'h00);
        check_frame(8'h00);
        send(8'hFF);
        check_frame(8'hFF);
        sel = 1'b0;

        // Reset in the middle of the data bits.
        send(8'h5A);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'b0, tx0}, 32'd1);
        check("midrst_busy", {31'b0, busy0}, 32'd0);
        check("midrst_done", {31'b0, done0}, 32'd0);
        check("midrst_ready", {31'b0, ready0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", {31'b0, ready0}, 32'd1);
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            check("midrst_quiet_tx", {31'b0, tx0}, 32'd1);
            check("midrst_no_done", {31'b0, done0}, 32'd0);
        end
        send(8'hC3);
        check_frame(8'hC3);

        // One-bit word, one clock per bit.
        @(negedge clk);
        din2   = 1'b1;
        valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("c1_tx", {31'b0, tx2}, {31'b0, exp2[c]});
            check("c1_busy", {31'b0, busy2}, 32'd1);
            check("c1_done_early", {31'b0, done2}, 32'd0);
            if (c == 0) check("c1_parity", {31'b0, par2}, 32'd1);
        end
        @(negedge clk);
        check("c1_done", {31'b0, done2}, 32'd1);
        check("c1_idle_tx", {31'b0, tx2}, 32'd1);
        check("c1_ready", {31'b0, ready2}, 32'd1);
        $display("frame dut2 word 1 parity %0b", par2);

        // Random valid toggling with random words.
        rx_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            valid0 = ($urandom_range(0, 2) == 0);
            din    = 8'($urandom);
        end
        valid0 = 1'b0;
        begin
            int t = 0;
            @(negedge clk);
            while ((busy0 || rx_active) && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("drain_timeout", {31'b0, (t < 200)}, 32'd1);
        end
        repeat (2) @(negedge clk);
        rx_en = 1'b0;
        check("rx_count", n_rx, n_acc);
        check("rx_leftover", acc_q.size(), 32'd0);
        check("rx_some_words", {31'b0, (n_acc > 5)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
